lfsr_checker: RTL

//  Receive-side counterpart of the internal (Galois) LFSR message generator.
//  - Consumes the stream of valid-qualified LFSR words feeding the DES unit.
//  - Regenerates the expected sequence locally from the same seed/polynomial and compares word by word.
//  - Reports sticky error, first failing index, mismatch total and completion.
//  - Sits beside the DES core as an in-system integrity monitor for the message source.

---
 rtl/lfsr_checker_if.sv | 29 ++
 rtl/lfsr_checker.sv | 101 ++++++++++
 2 files changed

// File: rtl/lfsr_checker_if.sv
// Handshake/config/result bundle between the LFSR word source and the checker.
interface lfsr_checker_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             reset_counter;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] polynomial;
  logic [WIDTH-1:0] counter_limit;
  logic [WIDTH-1:0] lfsr_in;
  logic             lfsr_valid;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] word_count;
  logic [WIDTH-1:0] mismatches;
  logic [WIDTH-1:0] fail_index;
  logic             error;
  logic             busy;
  logic             done;

  modport master (
    output start, reset_counter, seed, polynomial, counter_limit, lfsr_in, lfsr_valid,
    input  expected, word_count, mismatches, fail_index, error, busy, done
  );

  modport slave (
    input  start, reset_counter, seed, polynomial, counter_limit, lfsr_in, lfsr_valid,
    output expected, word_count, mismatches, fail_index, error, busy, done
  );
endinterface

// File: rtl/lfsr_checker.sv
// Galois LFSR stream checker: regenerates the expected sequence from seed/polynomial
// and compares each valid input word, keeping sticky error and first-failure index.
module lfsr_checker #(
  parameter int WIDTH = 64
) (
  input logic          clk,
  input logic          rst,
  lfsr_checker_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_expected, r_poly, r_limit;
  logic [WIDTH-1:0] r_word_count, r_mismatches, r_fail_index;
  logic             r_error;
  logic [WIDTH-1:0] w_step;
  logic             w_mis, w_last, w_take, w_busy, w_done;

  for (genvar i = 0; i < WIDTH-1; i++) begin : g_step
    assign w_step[i] = r_poly[i] ? (r_expected[i+1] ^ r_expected[0]) : r_expected[i+1];
  end
  assign w_step[WIDTH-1] = r_expected[0];

  assign w_mis  = bus.lfsr_in != r_expected;
  // Pre-increment compare so counter_limit=all-ones still terminates after the wrap.
  assign w_last = r_word_count == r_limit;
  assign w_take = (r_state == S_CHECK) && bus.lfsr_valid && !bus.reset_counter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.reset_counter)                  w_next = S_IDLE;
               else if (bus.start)                     w_next = S_CHECK;
      S_CHECK: if (bus.reset_counter)                  w_next = S_IDLE;
               else if (bus.lfsr_valid && w_last)      w_next = S_DONE;
      S_DONE:  if (bus.reset_counter)                  w_next = S_IDLE;
      default:                                         w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_CHECK: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expected   <= '0;
      r_poly       <= '0;
      r_limit      <= '0;
      r_word_count <= '0;
      r_mismatches <= '0;
      r_fail_index <= '0;
      r_error      <= 1'b0;
    end else if (bus.reset_counter) begin
      r_expected   <= '0;
      r_poly       <= '0;
      r_limit      <= '0;
      r_word_count <= '0;
      r_mismatches <= '0;
      r_fail_index <= '0;
      r_error      <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_expected   <= bus.seed;
      r_poly       <= bus.polynomial;
      r_limit      <= bus.counter_limit;
      r_word_count <= '0;
      r_mismatches <= '0;
      r_fail_index <= '0;
      r_error      <= 1'b0;
    end else if (w_take) begin
      if (w_mis) begin
        if (r_mismatches != '1) r_mismatches <= r_mismatches + WIDTH'(1);
        if (!r_error) begin
          r_error      <= 1'b1;
          r_fail_index <= r_word_count;
        end
      end
      r_word_count <= r_word_count + WIDTH'(1);
      r_expected   <= w_step;
    end
  end

  assign bus.expected   = r_expected;
  assign bus.word_count = r_word_count;
  assign bus.mismatches = r_mismatches;
  assign bus.fail_index = r_fail_index;
  assign bus.error      = r_error;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
endmodule
